// File: rtl/rst_seq.sv
// ============================================================================
// Module   : rst_seq
// Brief    : Staged reset-release sequencer with software reset replay and
//            a DFT bypass that routes the incoming reset to every stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq #(
  parameter int NumStages   = 4,
  parameter int DelayCycles = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_mode_i,
  input  logic                 sw_rst_req_i,
  output logic                 sw_rst_ack_o,
  output logic [NumStages-1:0] rst_no,
  output logic                 init_done_o
);

  localparam int c_CW = $clog2(DelayCycles + 1);
  localparam int c_IW = $clog2(NumStages + 1);

  localparam logic [c_CW-1:0] c_DLY_LAST   = c_CW'(DelayCycles - 1);
  localparam logic [c_IW-1:0] c_IDX_LAST   = c_IW'(NumStages - 1);
  localparam logic [c_IW-1:0] c_IDX_ASSERT = (NumStages >= 2) ? c_IW'(NumStages - 2) : '0;

  typedef enum logic [1:0] {
    S_RELEASE = 2'd0,
    S_RUN     = 2'd1,
    S_ASSERT  = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_CW-1:0]       r_cnt;
  logic [c_IW-1:0]       r_idx;
  logic [NumStages-1:0]  r_rst_n;
  logic                  r_init_done;
  logic                  r_ack;
  logic [NumStages-1:0]  w_sel;

  // One-hot stage select avoids indexing the stage vector with a wider index
  assign w_sel = NumStages'(1) << r_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_RELEASE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_n     <= '0;
      r_init_done <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_RELEASE: begin
          if (r_cnt == c_DLY_LAST) begin
            r_rst_n <= r_rst_n | w_sel;
            r_cnt   <= '0;
            r_idx   <= r_idx + c_IW'(1);
            if (r_idx == c_IDX_LAST) begin
              r_state <= S_RUN;
            end
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        S_RUN: begin
          r_init_done <= 1'b1;
          if (sw_rst_req_i) begin
            r_init_done <= 1'b0;
            if (NumStages == 1) begin
              r_rst_n <= '0;
              r_ack   <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_HOLD;
            end else begin
              r_rst_n[NumStages-1] <= 1'b0;
              r_idx                <= c_IDX_ASSERT;
              r_state              <= S_ASSERT;
            end
          end
        end
        S_ASSERT: begin
          r_rst_n <= r_rst_n & ~w_sel;
          if (r_idx == '0) begin
            r_ack   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_HOLD;
          end else begin
            r_idx <= r_idx - c_IW'(1);
          end
        end
        S_HOLD: begin
          if (r_cnt == c_DLY_LAST) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        default: r_state <= S_RELEASE;
      endcase
    end
  end

  // Test-mode bypass is the only combinational path onto the reset outputs
  assign rst_no       = test_mode_i ? {NumStages{rst_ni}} : r_rst_n;
  assign init_done_o  = test_mode_i ? rst_ni : r_init_done;
  assign sw_rst_ack_o = r_ack & ~test_mode_i;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq.sv
// ============================================================================
// Module   : tb_rst_seq
// Brief    : Directed self-checking bench for rst_seq (default and 1x1 builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_seq;

  logic       clk;
  logic       rst_n;
  logic       tm;
  logic       req;
  logic       ack;
  logic [3:0] rstv;
  logic       done;

  logic       rst1_n;
  logic       req1;
  logic       ack1;
  logic [0:0] rstv1;
  logic       done1;

  int cyc;
  int checks;
  int failures;
  logic ack_seen;

  rst_seq #(.NumStages(4), .DelayCycles(16)) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .test_mode_i  (tm),
    .sw_rst_req_i (req),
    .sw_rst_ack_o (ack),
    .rst_no       (rstv),
    .init_done_o  (done)
  );

  rst_seq #(.NumStages(1), .DelayCycles(1)) u_dut1 (
    .clk_i        (clk),
    .rst_ni       (rst1_n),
    .test_mode_i  (1'b0),
    .sw_rst_req_i (req1),
    .sw_rst_ack_o (ack1),
    .rst_no       (rstv1),
    .init_done_o  (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (ack) ack_seen = 1'b1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n    = 1'b1;
    cyc      = 0;
    ack_seen = 1'b0;
  endtask

  task automatic drop_rst(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_async_rst"}, 32'(rstv), 32'h0);
    check({tag, "_async_done"}, 32'(done), 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    ack_seen = 1'b0;
    rst_n    = 1'b0;
    rst1_n   = 1'b0;
    tm       = 1'b0;
    req      = 1'b0;
    req1     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rst", 32'(rstv), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_ack", 32'(ack), 32'h0);

    // Power-up release, with a request during RELEASE that must be ignored
    release_rst();
    run_to(15); check("pu_15", 32'(rstv), 32'h0);
    run_to(16); check("pu_16", 32'(rstv), 32'h1);
    run_to(19); req = 1'b1;
    run_to(20); req = 1'b0;
    run_to(31); check("pu_31", 32'(rstv), 32'h1);
    run_to(32); check("pu_32", 32'(rstv), 32'h3);
    run_to(48); check("pu_48", 32'(rstv), 32'h7);
    run_to(64); check("pu_64", 32'(rstv), 32'hF);
    check("pu_64_done", 32'(done), 32'h0);
    run_to(65); check("pu_65_done", 32'(done), 32'h1);
    check("pu_ack_never", 32'(ack_seen), 32'h0);

    // Software reset sampled at edge 100
    run_to(99); req = 1'b1;
    run_to(100); req = 1'b0;
    check("sw_100", 32'(rstv), 32'h7);
    check("sw_100_done", 32'(done), 32'h0);
    check("sw_100_ack", 32'(ack), 32'h0);
    run_to(101); check("sw_101", 32'(rstv), 32'h3);
    run_to(102); check("sw_102", 32'(rstv), 32'h1);
    check("sw_102_ack", 32'(ack), 32'h0);
    run_to(103); check("sw_103", 32'(rstv), 32'h0);
    check("sw_103_ack", 32'(ack), 32'h1);
    run_to(104); check("sw_104_ack", 32'(ack), 32'h0);
    run_to(134); check("sw_134", 32'(rstv), 32'h0);
    run_to(135); check("sw_135", 32'(rstv), 32'h1);
    run_to(183); check("sw_183", 32'(rstv), 32'hF);
    check("sw_183_done", 32'(done), 32'h0);
    run_to(184); check("sw_184_done", 32'(done), 32'h1);

    // Request held high from power-up: ignored until RUN, then fires at 65
    drop_rst("run");
    req = 1'b1;
    release_rst();
    run_to(64); check("held_64", 32'(rstv), 32'hF);
    run_to(65); check("held_65", 32'(rstv), 32'h7);
    check("held_65_done", 32'(done), 32'h0);
    run_to(68); check("held_68", 32'(rstv), 32'h0);
    check("held_68_ack", 32'(ack), 32'h1);
    req = 1'b0;
    run_to(99); check("held_99", 32'(rstv), 32'h0);
    run_to(100); check("held_100", 32'(rstv), 32'h1);

    // Abort during RELEASE
    drop_rst("held");
    release_rst();
    run_to(40); check("mid_rel_40", 32'(rstv), 32'h3);
    drop_rst("mid_rel");
    release_rst();
    run_to(15); check("mid_rel_re15", 32'(rstv), 32'h0);
    run_to(16); check("mid_rel_re16", 32'(rstv), 32'h1);

    // Abort during ASSERT
    run_to(69); req = 1'b1;
    run_to(70); req = 1'b0;
    run_to(71); check("mid_as_71", 32'(rstv), 32'h3);
    drop_rst("mid_as");
    release_rst();
    run_to(15); check("mid_as_re15", 32'(rstv), 32'h0);
    run_to(16); check("mid_as_re16", 32'(rstv), 32'h1);

    // Abort during HOLD
    run_to(69); req = 1'b1;
    run_to(70); req = 1'b0;
    run_to(73); check("mid_hd_73_ack", 32'(ack), 32'h1);
    run_to(80); check("mid_hd_80", 32'(rstv), 32'h0);
    drop_rst("mid_hd");
    release_rst();
    run_to(15); check("mid_hd_re15", 32'(rstv), 32'h0);
    run_to(16); check("mid_hd_re16", 32'(rstv), 32'h1);
    check("mid_hd_ack_never", 32'(ack_seen), 32'h0);

    // Test-mode bypass, changed between edges
    @(negedge clk);
    tm = 1'b1;
    #1;
    check("tm_hi_rst", 32'(rstv), 32'hF);
    check("tm_hi_done", 32'(done), 32'h1);
    check("tm_hi_ack", 32'(ack), 32'h0);
    rst_n = 1'b0;
    #1;
    check("tm_lo_rst", 32'(rstv), 32'h0);
    check("tm_lo_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    #1;
    check("tm_hi2_rst", 32'(rstv), 32'hF);
    tm = 1'b0;
    #1;
    check("tm_off_rst", 32'(rstv), 32'h0);

    // Corner build: one stage, one-cycle delay
    check("c1_reset_rst", 32'(rstv1), 32'h0);
    check("c1_reset_done", 32'(done1), 32'h0);
    @(negedge clk);
    rst1_n = 1'b1;
    cyc    = 0;
    run_to(1); check("c1_1_rst", 32'(rstv1), 32'h1);
    check("c1_1_done", 32'(done1), 32'h0);
    run_to(2); check("c1_2_done", 32'(done1), 32'h1);
    run_to(4); req1 = 1'b1;
    run_to(5); req1 = 1'b0;
    check("c1_5_rst", 32'(rstv1), 32'h0);
    check("c1_5_ack", 32'(ack1), 32'h1);
    check("c1_5_done", 32'(done1), 32'h0);
    run_to(6); check("c1_6_rst", 32'(rstv1), 32'h0);
    check("c1_6_ack", 32'(ack1), 32'h0);
    run_to(7); check("c1_7_rst", 32'(rstv1), 32'h1);
    run_to(8); check("c1_8_done", 32'(done1), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
